// File: rtl/bin2bcd_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_seq_if
//  Purpose  : Request/response handshake bundle for the bin2bcd_seq converter.
//  Revision : 1.0
// ============================================================================
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic                  neg;
    logic                  ovf;

    modport master (
        output in_valid, bin, out_ready,
        input  in_ready, out_valid, bcd, neg, ovf
    );

    modport slave (
        input  in_valid, bin, out_ready,
        output in_ready, out_valid, bcd, neg, ovf
    );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_seq
//  Purpose  : Iterative double-dabble binary-to-BCD converter, one shift/clock.
//  Revision : 1.0
// ============================================================================
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3,
    parameter bit SIGNED = 1'b0
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    bin2bcd_seq_if.slave       bus
);
    localparam int                ACC_W     = 4 * DIGITS;
    localparam int                CNT_W     = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [BIN_W-1:0]   mag_q, mag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [ACC_W-1:0]   acc_adj;
    logic               bin_is_neg;
    logic [BIN_W-1:0]   bin_mag;

    // Per-digit add-3 stays inside 4 bits, so no carry ever reaches the next digit.
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            logic [3:0] dig;
            assign dig                 = acc_q[4*g +: 4];
            assign acc_adj[4*g +: 4]   = (dig >= 4'd5) ? (dig + 4'd3) : dig;
        end
    endgenerate

    generate
        if (SIGNED) begin : g_signed
            assign bin_is_neg = bus.bin[BIN_W-1];
        end else begin : g_unsigned
            assign bin_is_neg = 1'b0;
        end
    endgenerate

    // The most negative input negates to 2^(BIN_W-1), which fits as an unsigned BIN_W value.
    assign bin_mag = bin_is_neg ? (~bus.bin + BIN_W'(1)) : bus.bin;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mag_d   = mag_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_ready_q && bus.in_valid) begin
                    mag_d   = bin_mag;
                    neg_d   = bin_is_neg;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                acc_d = {acc_adj[ACC_W-2:0], mag_q[BIN_W-1]};
                mag_d = {mag_q[BIN_W-2:0], 1'b0};
                ovf_d = ovf_q | acc_adj[ACC_W-1];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            mag_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.bcd       = acc_q;
    assign bus.neg       = neg_q;
    assign bus.ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bin2bcd_seq
//  Purpose  : Four converter configurations driven in lockstep against a decimal model.
//  Revision : 1.0
// ============================================================================
module tb_bin2bcd_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tb_in_valid = 1'b0;
    logic       tb_out_ready = 1'b0;
    logic [7:0] tb_bin = 8'h00;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bin2bcd_seq_if #(.BIN_W(4), .DIGITS(2)) if0 ();
    bin2bcd_seq_if #(.BIN_W(8), .DIGITS(3)) if1 ();
    bin2bcd_seq_if #(.BIN_W(8), .DIGITS(3)) if2 ();
    bin2bcd_seq_if #(.BIN_W(8), .DIGITS(2)) if3 ();

    assign if0.in_valid = tb_in_valid;
    assign if1.in_valid = tb_in_valid;
    assign if2.in_valid = tb_in_valid;
    assign if3.in_valid = tb_in_valid;
    assign if0.out_ready = tb_out_ready;
    assign if1.out_ready = tb_out_ready;
    assign if2.out_ready = tb_out_ready;
    assign if3.out_ready = tb_out_ready;
    assign if0.bin = tb_bin[3:0];
    assign if1.bin = tb_bin;
    assign if2.bin = tb_bin;
    assign if3.bin = tb_bin;

    bin2bcd_seq #(.BIN_W(4), .DIGITS(2), .SIGNED(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1'b0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1'b1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    bin2bcd_seq #(.BIN_W(8), .DIGITS(2), .SIGNED(1'b0)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Decimal digits of val, low digit first; digits beyond the count are simply dropped.
    function automatic logic [31:0] to_bcd(input int unsigned val, input int digits);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = val;
        for (int i = 0; i < digits; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!(if0.in_ready && if1.in_ready && if2.in_ready && if3.in_ready) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_vec(input logic [7:0] v, input int hold);
        int unsigned u4, u8, mag;
        logic [31:0] exp1;
        u4   = int'(v[3:0]);
        u8   = int'(v);
        mag  = v[7] ? (256 - u8) : u8;
        exp1 = to_bcd(u8, 3);

        wait_ready();
        tb_bin      = v;
        tb_in_valid = 1'b1;
        @(posedge clk); #1;
        tb_in_valid = 1'b0;
        tb_bin      = ~v;
        chk("busy_rdy", {31'd0, if1.in_ready}, 32'd0);

        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 3) chk("lat4_early", {31'd0, if0.out_valid}, 32'd0);
            if (k == 4) chk("lat4", {31'd0, if0.out_valid}, 32'd1);
            if (k == 7) chk("lat8_early", {29'd0, if1.out_valid, if2.out_valid, if3.out_valid}, 32'd0);
            if (k == 8) chk("lat8", {29'd0, if1.out_valid, if2.out_valid, if3.out_valid}, 32'd7);
        end

        chk("bcd_w4",  {24'd0, if0.bcd},  to_bcd(u4, 2));
        chk("ovf_w4",  {31'd0, if0.ovf},  32'd0);
        chk("bcd_u8",  {20'd0, if1.bcd},  exp1);
        chk("ovf_u8",  {31'd0, if1.ovf},  32'd0);
        chk("neg_u8",  {31'd0, if1.neg},  32'd0);
        chk("bcd_s8",  {20'd0, if2.bcd},  to_bcd(mag, 3));
        chk("neg_s8",  {31'd0, if2.neg},  {31'd0, v[7]});
        chk("ovf_s8",  {31'd0, if2.ovf},  32'd0);
        chk("bcd_d2",  {24'd0, if3.bcd},  to_bcd(u8, 2));
        chk("ovf_d2",  {31'd0, if3.ovf},  (u8 >= 100) ? 32'd1 : 32'd0);

        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, if1.out_valid}, 32'd1);
            chk("hold_bcd",   {20'd0, if1.bcd},       exp1);
            chk("hold_rdy",   {31'd0, if1.in_ready},  32'd0);
        end

        tb_out_ready = 1'b1;
        @(posedge clk); #1;
        tb_out_ready = 1'b0;
        chk("release_valid", {28'd0, if0.out_valid, if1.out_valid, if2.out_valid, if3.out_valid}, 32'd0);
        chk("release_rdy",   {31'd0, if1.in_ready}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_rdy",   {28'd0, if0.in_ready, if1.in_ready, if2.in_ready, if3.in_ready}, 32'd0);
        chk("rst_valid", {28'd0, if0.out_valid, if1.out_valid, if2.out_valid, if3.out_valid}, 32'd0);
        chk("rst_bcd",   {20'd0, if1.bcd}, 32'd0);
        chk("rst_flags", {28'd0, if1.ovf, if2.neg, if2.ovf, if3.ovf}, 32'd0);
        #10 rst_n = 1'b1;

        for (int v = 1; v <= 15; v++) run_vec(8'(v), 0);
        run_vec(8'd255, 5);
        run_vec(8'd0,   0);
        run_vec(8'h80,  0);
        run_vec(8'hFF,  0);
        run_vec(8'h7F,  0);
        run_vec(8'd200, 0);
        run_vec(8'd99,  0);
        run_vec(8'd100, 2);

        // Abort a conversion after its third step; outputs must clear without waiting for an edge.
        wait_ready();
        tb_bin      = 8'h9C;
        tb_in_valid = 1'b1;
        @(posedge clk); #1;
        tb_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_neg_before", {31'd0, if2.neg}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_bcd",   {20'd0, if2.bcd}, 32'd0);
        chk("async_neg",   {31'd0, if2.neg}, 32'd0);
        chk("async_valid", {28'd0, if0.out_valid, if1.out_valid, if2.out_valid, if3.out_valid}, 32'd0);
        chk("async_rdy",   {28'd0, if0.in_ready, if1.in_ready, if2.in_ready, if3.in_ready}, 32'd0);
        chk("async_ovf",   {28'd0, if0.ovf, if1.ovf, if2.ovf, if3.ovf}, 32'd0);
        #20 rst_n = 1'b1;
        run_vec(8'd37, 0);

        for (int i = 0; i < 25; i++) run_vec(8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
